mem_wb_stage: RTL

Memory stage plus MEM/WB pipeline register for the 16-bit pipeline. It consumes the EX/MEM register outputs and runs loads and stores against a data memory over a req/ready handshake. While an access is outstanding it stalls the upstream pipeline. It then registers the selected write-back value, destination and regwrite for the write-back stage.

---
 rtl/mem_wb_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: runs loads/stores over a
// req/ready handshake, stalls upstream while busy, registers write-back.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwrite_current,
  input  logic        memtoreg_current,
  input  logic        memwrite_current,
  input  logic [15:0] mem_addr_current,
  input  logic [15:0] alu_source_2_current,
  input  logic [15:0] reg_write_data_current,
  input  logic [3:0]  reg_write_select_current,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        wb_regwrite,
  output logic [3:0]  wb_select,
  output logic [15:0] wb_data,
  output logic        err_timeout
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 8;
  localparam logic [CW:0] TO_LIM = (CW+1)'(TIMEOUT);
  localparam logic        WD_EN  = (TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hold_we_q, hold_we_d;
  logic [DW-1:0]   hold_addr_q, hold_addr_d;
  logic [DW-1:0]   hold_wdata_q, hold_wdata_d;
  logic            mem_req_q, mem_req_d;
  logic            wb_regwrite_q, wb_regwrite_d;
  logic [RW-1:0]   wb_select_q, wb_select_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic            err_q, err_d;

  logic            access_c;
  logic            timeout_hit_c;
  logic            stall_c;

  assign access_c = memwrite_current | memtoreg_current;

  // Abort fires on the TIMEOUT-th BUSY cycle that sees no ready.
  assign timeout_hit_c = WD_EN && (state_q == BUSY) && !mem_ready &&
                         (({1'b0, cnt_q} + (CW+1)'(1)) == TO_LIM);

  // Next-state, hold capture and MEM/WB load selection.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_we_d     = hold_we_q;
    hold_addr_d   = hold_addr_q;
    hold_wdata_d  = hold_wdata_q;
    mem_req_d     = mem_req_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_select_d   = wb_select_q;
    wb_data_d     = wb_data_q;
    err_d         = err_q;
    stall_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (access_c) begin
          stall_c       = 1'b1;
          state_d       = BUSY;
          cnt_d         = '0;
          hold_we_d     = memwrite_current;
          hold_addr_d   = mem_addr_current;
          hold_wdata_d  = alu_source_2_current;
          mem_req_d     = 1'b1;
          wb_regwrite_d = 1'b0;
        end else begin
          wb_regwrite_d = regwrite_current;
          wb_select_d   = reg_write_select_current;
          wb_data_d     = reg_write_data_current;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d       = IDLE;
          mem_req_d     = 1'b0;
          wb_regwrite_d = regwrite_current;
          wb_select_d   = reg_write_select_current;
          // A store (even with memtoreg set) writes back the ALU result.
          wb_data_d     = hold_we_q ? reg_write_data_current : mem_rdata;
        end else if (timeout_hit_c) begin
          state_d       = IDLE;
          mem_req_d     = 1'b0;
          err_d         = 1'b1;
          wb_regwrite_d = 1'b0;
          wb_data_d     = '0;
        end else begin
          stall_c       = 1'b1;
          wb_regwrite_d = 1'b0;
          if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_we_q     <= 1'b0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= '0;
      mem_req_q     <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_select_q   <= '0;
      wb_data_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_we_q     <= hold_we_d;
      hold_addr_q   <= hold_addr_d;
      hold_wdata_q  <= hold_wdata_d;
      mem_req_q     <= mem_req_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_select_q   <= wb_select_d;
      wb_data_q     <= wb_data_d;
      err_q         <= err_d;
    end
  end

  // Stall is forced low while reset is held so upstream is not frozen.
  assign stall       = stall_c & rst;
  assign mem_req     = mem_req_q;
  assign mem_we      = hold_we_q;
  assign mem_addr    = hold_addr_q;
  assign mem_wdata   = hold_wdata_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_select   = wb_select_q;
  assign wb_data     = wb_data_q;
  assign err_timeout = err_q;

endmodule
